// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg -- shared constants, tables and helpers for the DES decryption engine.
//
// Bit numbering: DES numbers bits from 1 at the MSB. Every permutation helper
// below takes its table in that numbering. Output position i (0-based from the
// MSB) is filled with input DES bit TBL[i].
//
// Contents:
//   block_t          8x8 packed byte block, byte [7] first on the wire
//   state_e          engine FSM states
//   IP/FP/E/P/PC1/PC2 permutation tables, SBOX_TBL S-boxes, SHIFT_TBL schedule
//   des_ip/des_fp/des_e/des_p/des_pc1/des_pc2  permutation functions
//   des_sbox         single S-box lookup
//   des_rotr         28-bit right rotate for the decryption key schedule
// -----------------------------------------------------------------------------
package des_pkg;

  typedef logic [7:0][7:0] block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] LAST_ROUND = 4'd15;

  localparam logic [7:0] IP_TBL [64] = '{
    8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,
    8'd60, 8'd52, 8'd44, 8'd36, 8'd28, 8'd20, 8'd12, 8'd4,
    8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22, 8'd14, 8'd6,
    8'd64, 8'd56, 8'd48, 8'd40, 8'd32, 8'd24, 8'd16, 8'd8,
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,
    8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
    8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7
  };

  localparam logic [7:0] FP_TBL [64] = '{
    8'd40, 8'd8, 8'd48, 8'd16, 8'd56, 8'd24, 8'd64, 8'd32,
    8'd39, 8'd7, 8'd47, 8'd15, 8'd55, 8'd23, 8'd63, 8'd31,
    8'd38, 8'd6, 8'd46, 8'd14, 8'd54, 8'd22, 8'd62, 8'd30,
    8'd37, 8'd5, 8'd45, 8'd13, 8'd53, 8'd21, 8'd61, 8'd29,
    8'd36, 8'd4, 8'd44, 8'd12, 8'd52, 8'd20, 8'd60, 8'd28,
    8'd35, 8'd3, 8'd43, 8'd11, 8'd51, 8'd19, 8'd59, 8'd27,
    8'd34, 8'd2, 8'd42, 8'd10, 8'd50, 8'd18, 8'd58, 8'd26,
    8'd33, 8'd1, 8'd41, 8'd9,  8'd49, 8'd17, 8'd57, 8'd25
  };

  localparam logic [7:0] E_TBL [48] = '{
    8'd32, 8'd1,  8'd2,  8'd3,  8'd4,  8'd5,
    8'd4,  8'd5,  8'd6,  8'd7,  8'd8,  8'd9,
    8'd8,  8'd9,  8'd10, 8'd11, 8'd12, 8'd13,
    8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17,
    8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd21,
    8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25,
    8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29,
    8'd28, 8'd29, 8'd30, 8'd31, 8'd32, 8'd1
  };

  localparam logic [7:0] P_TBL [32] = '{
    8'd16, 8'd7,  8'd20, 8'd21, 8'd29, 8'd12, 8'd28, 8'd17,
    8'd1,  8'd15, 8'd23, 8'd26, 8'd5,  8'd18, 8'd31, 8'd10,
    8'd2,  8'd8,  8'd24, 8'd14, 8'd32, 8'd27, 8'd3,  8'd9,
    8'd19, 8'd13, 8'd30, 8'd6,  8'd22, 8'd11, 8'd4,  8'd25
  };

  // Parity bits 8,16,...,64 never appear here, which is what makes the key
  // parity irrelevant.
  localparam logic [7:0] PC1_TBL [56] = '{
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,
    8'd1,  8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18,
    8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27,
    8'd19, 8'd11, 8'd3,  8'd60, 8'd52, 8'd44, 8'd36,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15,
    8'd7,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22,
    8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37, 8'd29,
    8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
  };

  localparam logic [7:0] PC2_TBL [48] = '{
    8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,
    8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
    8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,
    8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
    8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55,
    8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
    8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53,
    8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
  };

  // Each S-box is 64 nibbles, row-major (row 0 col 0 in the top nibble).
  localparam logic [255:0] SBOX_TBL [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // Right-rotate amount applied after decryption round k, i.e. the encryption
  // shifts for rounds 16 down to 2. Nothing rotates after the last round.
  localparam logic [1:0] SHIFT_TBL [16] = '{
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0
  };

  function automatic logic [63:0] des_ip(input logic [63:0] x);
    logic [63:0] y;
    y = 64'd0;
    for (int i = 0; i < 64; i++) y[63 - i] = x[64 - int'(IP_TBL[i])];
    return y;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] x);
    logic [63:0] y;
    y = 64'd0;
    for (int i = 0; i < 64; i++) y[63 - i] = x[64 - int'(FP_TBL[i])];
    return y;
  endfunction

  function automatic logic [47:0] des_e(input logic [31:0] x);
    logic [47:0] y;
    y = 48'd0;
    for (int i = 0; i < 48; i++) y[47 - i] = x[32 - int'(E_TBL[i])];
    return y;
  endfunction

  function automatic logic [31:0] des_p(input logic [31:0] x);
    logic [31:0] y;
    y = 32'd0;
    for (int i = 0; i < 32; i++) y[31 - i] = x[32 - int'(P_TBL[i])];
    return y;
  endfunction

  function automatic logic [55:0] des_pc1(input logic [63:0] x);
    logic [55:0] y;
    y = 56'd0;
    for (int i = 0; i < 56; i++) y[55 - i] = x[64 - int'(PC1_TBL[i])];
    return y;
  endfunction

  function automatic logic [47:0] des_pc2(input logic [55:0] x);
    logic [47:0] y;
    y = 48'd0;
    for (int i = 0; i < 48; i++) y[47 - i] = x[56 - int'(PC2_TBL[i])];
    return y;
  endfunction

  // Row comes from the outer bits, column from the middle four.
  function automatic logic [3:0] des_sbox(input int box, input logic [5:0] b);
    logic [5:0]   idx;
    logic [7:0]   sh;
    logic [255:0] t;
    idx = {b[5], b[0], b[4:1]};
    sh  = {idx, 2'b00};
    t   = SBOX_TBL[box] << sh;
    return t[255:252];
  endfunction

  function automatic logic [27:0] des_rotr(input logic [27:0] x, input logic [1:0] n);
    logic [27:0] y;
    case (n)
      2'd1:    y = {x[0], x[27:1]};
      2'd2:    y = {x[1:0], x[27:2]};
      default: y = x;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/des_round.sv
// -----------------------------------------------------------------------------
// des_round -- one combinational DES Feistel round.
//
//   l_i  [31:0]  left half entering the round
//   r_i  [31:0]  right half entering the round
//   k_i  [47:0]  round subkey
//   l_o  [31:0]  new left half  (= r_i)
//   r_o  [31:0]  new right half (= l_i ^ f(r_i, k_i))
// -----------------------------------------------------------------------------
module des_round
  import des_pkg::*;
(
  input  logic [31:0] l_i,
  input  logic [31:0] r_i,
  input  logic [47:0] k_i,
  output logic [31:0] l_o,
  output logic [31:0] r_o
);

  logic [47:0] mix_s;
  logic [31:0] sbox_s;

  assign mix_s = des_e(r_i) ^ k_i;

  // Eight 6-in/4-out substitutions, S1 on the most significant bits.
  always_comb begin
    sbox_s = 32'd0;
    for (int b = 0; b < 8; b++) begin
      sbox_s[31 - 4*b -: 4] = des_sbox(b, mix_s[47 - 6*b -: 6]);
    end
  end

  assign l_o = r_i;
  assign r_o = l_i ^ des_p(sbox_s);

endmodule

// File: rtl/decrypt.sv
// -----------------------------------------------------------------------------
// decrypt -- iterative DES decryption engine, one Feistel round per clock.
//
//   message   [63:0] in   ciphertext, byte [7] first, bit 63 = DES bit 1
//   DESkey    [63:0] in   key, same ordering, parity bits ignored
//   decrypted [63:0] out  plaintext, updated only when a block completes
//   done             out  result valid, held until ack
//   clk              in   rising-edge clock
//   reset            in   asynchronous active-low reset
//   enable           in   start request, looked at only in IDLE
//   ack              in   result acknowledge, looked at only in DONE
// -----------------------------------------------------------------------------
module decrypt
  import des_pkg::*;
(
  input  block_t message,
  input  block_t DESkey,
  output block_t decrypted,
  output logic   done,
  input  logic   clk,
  input  logic   reset,
  input  logic   enable,
  input  logic   ack
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [63:0] dec_q, dec_d;
  logic        done_q, done_d;

  logic [63:0] ip_s;
  logic [55:0] pc1_s;
  logic [47:0] subkey_s;
  logic [31:0] rnd_l_s, rnd_r_s;

  assign ip_s  = des_ip(message);
  assign pc1_s = des_pc1(DESkey);

  // C/D already hold the schedule position for the current round, starting
  // at K16 straight out of PC-1.
  assign subkey_s = des_pc2({c_q, d_q});

  des_round u_round (
    .l_i (l_q),
    .r_i (r_q),
    .k_i (subkey_s),
    .l_o (rnd_l_s),
    .r_o (rnd_r_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = ROUND;
        else        state_d = IDLE;
      end
      ROUND: begin
        if (cnt_q == LAST_ROUND) state_d = DONE;
        else                     state_d = ROUND;
      end
      DONE: begin
        if (ack) state_d = IDLE;
        else     state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    cnt_d  = cnt_q;
    l_d    = l_q;
    r_d    = r_q;
    c_d    = c_q;
    d_d    = d_q;
    dec_d  = dec_q;
    done_d = done_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          l_d   = ip_s[63:32];
          r_d   = ip_s[31:0];
          c_d   = pc1_s[55:28];
          d_d   = pc1_s[27:0];
          cnt_d = 4'd0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ROUND: begin
        l_d   = rnd_l_s;
        r_d   = rnd_r_s;
        c_d   = des_rotr(c_q, SHIFT_TBL[cnt_q]);
        d_d   = des_rotr(d_q, SHIFT_TBL[cnt_q]);
        cnt_d = cnt_q + 4'd1;
        // The last round's halves are swapped (R16 first) before FP.
        if (cnt_q == LAST_ROUND) begin
          dec_d  = des_fp({rnd_r_s, rnd_l_s});
          done_d = 1'b1;
        end else begin
          done_d = 1'b0;
        end
      end
      DONE: begin
        if (ack) done_d = 1'b0;
        else     done_d = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= 4'd0;
      l_q    <= 32'd0;
      r_q    <= 32'd0;
      c_q    <= 28'd0;
      d_q    <= 28'd0;
      dec_q  <= 64'd0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      l_q    <= l_d;
      r_q    <= r_d;
      c_q    <= c_d;
      d_q    <= d_d;
      dec_q  <= dec_d;
      done_q <= done_d;
    end
  end

  assign decrypted = dec_q;
  assign done      = done_q;

endmodule

// File: tb/tb_decrypt.sv
// -----------------------------------------------------------------------------
// tb_decrypt -- directed test of the DES decryption engine: known-answer
// vectors from a table, plus handshake, reset-abort and back-to-back sequences.
// -----------------------------------------------------------------------------
module tb_decrypt;

  logic [63:0] message;
  logic [63:0] DESkey;
  logic [63:0] decrypted;
  logic        done;
  logic        clk;
  logic        reset;
  logic        enable;
  logic        ack;

  int n_checks;
  int n_fail;
  int cyc;

  typedef struct {
    logic [63:0] key;
    logic [63:0] msg;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [4];

  decrypt dut (
    .message   (message),
    .DESkey    (DESkey),
    .decrypted (decrypted),
    .done      (done),
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .ack       (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Pulse enable for one cycle, then scramble the inputs to show they were captured.
  task automatic start(input logic [63:0] key, input logic [63:0] msg);
    @(negedge clk);
    message = msg;
    DESkey  = key;
    enable  = 1'b1;
    @(negedge clk);
    enable  = 1'b0;
    message = {$urandom, $urandom};
    DESkey  = {$urandom, $urandom};
  endtask

  // Called right after start(): done must appear exactly 16 edges after capture.
  task automatic finish_check(input string name, input logic [63:0] exp);
    repeat (15) @(negedge clk);
    check({name, "_done_early"}, {63'd0, done}, 64'd0);
    @(negedge clk);
    check({name, "_done"}, {63'd0, done}, 64'd1);
    check({name, "_data"}, decrypted, exp);
  endtask

  task automatic ack_check(input string name, input logic [63:0] exp);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check({name, "_ack_done"}, {63'd0, done}, 64'd0);
    check({name, "_ack_data"}, decrypted, exp);
  endtask

  task automatic wait_done(input string name, input int limit, output int at_cyc);
    int k;
    k = 0;
    at_cyc = -1;
    while (k < limit) begin
      @(negedge clk);
      k++;
      if (done) begin
        at_cyc = cyc;
        break;
      end
    end
    if (at_cyc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: done not seen within %0d cycles", name, limit);
    end
  endtask

  initial begin
    int c1;
    int c2;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    enable   = 1'b0;
    ack      = 1'b0;
    message  = 64'd0;
    DESkey   = 64'd0;

    vecs[0] = '{key: 64'h133457799BBCDFF1, msg: 64'h85E813540F0AB405, exp: 64'h0123456789ABCDEF};
    vecs[1] = '{key: 64'h0000000000000000, msg: 64'h8CA64DE9C1B123A7, exp: 64'h0000000000000000};
    vecs[2] = '{key: 64'h0E329232EA6D0D73, msg: 64'h0000000000000000, exp: 64'h8787878787878787};
    vecs[3] = '{key: 64'h0F339333EB6C0C72, msg: 64'h0000000000000000, exp: 64'h8787878787878787};

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_data", decrypted, 64'd0);
    reset = 1'b1;

    // Known-answer table.
    for (int i = 0; i < 4; i++) begin
      start(vecs[i].key, vecs[i].msg);
      finish_check($sformatf("vec%0d", i), vecs[i].exp);
      ack_check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // done held for 10 cycles without ack.
    start(vecs[0].key, vecs[0].msg);
    finish_check("hold", vecs[0].exp);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold_done_%0d", i), {63'd0, done}, 64'd1);
    end
    check("hold_data", decrypted, vecs[0].exp);
    ack_check("hold", vecs[0].exp);

    // enable during ROUND ignored; enable with ack in DONE ignored.
    start(vecs[2].key, vecs[2].msg);
    repeat (5) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (9) @(negedge clk);
    check("round_en_early", {63'd0, done}, 64'd0);
    @(negedge clk);
    check("round_en_done", {63'd0, done}, 64'd1);
    check("round_en_data", decrypted, vecs[2].exp);
    message = vecs[0].msg;
    DESkey  = vecs[0].key;
    enable  = 1'b1;
    ack     = 1'b1;
    @(negedge clk);
    enable  = 1'b0;
    ack     = 1'b0;
    check("done_en_ack_done", {63'd0, done}, 64'd0);
    repeat (20) @(negedge clk);
    check("done_en_no_restart", {63'd0, done}, 64'd0);
    check("done_en_data", decrypted, vecs[2].exp);

    // Reset in the middle of round 8 aborts and clears outputs.
    start(vecs[0].key, vecs[0].msg);
    repeat (8) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_data", decrypted, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    start(vecs[0].key, vecs[0].msg);
    finish_check("after_abort", vecs[0].exp);
    ack_check("after_abort", vecs[0].exp);

    // Back-to-back with enable and ack held high.
    @(negedge clk);
    message = vecs[0].msg;
    DESkey  = vecs[0].key;
    enable  = 1'b1;
    ack     = 1'b1;
    wait_done("b2b_first", 40, c1);
    check("b2b_first_data", decrypted, vecs[0].exp);
    message = vecs[3].msg;
    DESkey  = vecs[3].key;
    @(negedge clk);
    check("b2b_gap_done", {63'd0, done}, 64'd0);
    wait_done("b2b_second", 40, c2);
    check("b2b_second_data", decrypted, vecs[3].exp);
    check("b2b_spacing", 64'(c2 - c1), 64'd18);
    enable = 1'b0;
    @(negedge clk);
    ack = 1'b0;
    check("b2b_end_done", {63'd0, done}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
